// File: rtl/call_sched_pkg.sv
// Shared definitions for the elevator call scheduler: FSM encoding, sweep
// direction constants and watchdog sizing.
package call_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SELECT    = 2'd1,
        ST_OFFER     = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned WDOG_W         = 8;
    localparam int unsigned TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/call_sched_if.sv
// Target-offer handshake between the call scheduler and the lift controller.
interface call_sched_if #(
    parameter int unsigned FLOOR_W = 3
);
    logic [FLOOR_W-1:0] elev_f_i;
    logic               busy_i;
    logic               req_ack_i;
    logic               req_valid_o;
    logic [FLOOR_W-1:0] req_floor_o;

    modport master (
        input  elev_f_i, busy_i, req_ack_i,
        output req_valid_o, req_floor_o
    );

    modport slave (
        output elev_f_i, busy_i, req_ack_i,
        input  req_valid_o, req_floor_o
    );
endinterface

// File: rtl/call_pick.sv
// Combinational sweep selection: current floor first, then nearest pending
// floor in the sweep direction, otherwise reverse and take the nearest.
module call_pick
    import call_sched_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned FLOOR_W    = 3
) (
    input  logic [NUM_FLOORS-1:0] pending_i,
    input  logic [FLOOR_W-1:0]    elev_f_i,
    input  logic                  dir_i,
    output logic [FLOOR_W-1:0]    target_o,
    output logic                  dir_o,
    output logic                  found_o
);
    localparam int unsigned IDX_W = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;

    logic [FLOOR_W-1:0] elev_c;
    logic [FLOOR_W-1:0] up_f;
    logic [FLOOR_W-1:0] dn_f;
    logic               here;
    logic               up_found;
    logic               dn_found;

    always_comb begin
        elev_c   = (32'(elev_f_i) >= NUM_FLOORS) ? FLOOR_W'(NUM_FLOORS - 1) : elev_f_i;
        here     = 1'b0;
        up_found = 1'b0;
        dn_found = 1'b0;
        up_f     = '0;
        dn_f     = '0;
        // Ascending scan: first hit above is the nearest up, last hit below the nearest down.
        for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
            if (pending_i[IDX_W'(f)]) begin
                if (FLOOR_W'(f) == elev_c) here = 1'b1;
                if (FLOOR_W'(f) < elev_c) begin
                    dn_f     = FLOOR_W'(f);
                    dn_found = 1'b1;
                end
                if ((FLOOR_W'(f) > elev_c) && !up_found) begin
                    up_f     = FLOOR_W'(f);
                    up_found = 1'b1;
                end
            end
        end

        found_o  = here | up_found | dn_found;
        target_o = elev_c;
        dir_o    = dir_i;
        if (!here) begin
            if (dir_i == DIR_UP) begin
                if (up_found) begin
                    target_o = up_f;
                end else if (dn_found) begin
                    target_o = dn_f;
                    dir_o    = DIR_DOWN;
                end
            end else begin
                if (dn_found) begin
                    target_o = dn_f;
                end else if (up_found) begin
                    target_o = up_f;
                    dir_o    = DIR_UP;
                end
            end
        end
    end
endmodule

// File: rtl/call_scheduler.sv
// Elevator call scheduler: latches hall/cab calls and offers sweep-ordered
// targets to the lift controller. Optional watchdog: CALL_SCHED_TIMEOUT_EN.
module call_scheduler
    import call_sched_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned FLOOR_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] hall_call,
    input  logic [NUM_FLOORS-1:0] cab_call,
    call_sched_if.master          lift,
    output logic                  dir_o,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  timeout_o
);
    state_e                  state_q, state_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic                    dir_q, dir_d;
    logic                    req_valid_q, req_valid_d;
    logic [FLOOR_W-1:0]      req_floor_q, req_floor_d;
    logic [NUM_FLOORS-1:0]   floor_mask_c;
    logic [FLOOR_W-1:0]      pick_floor;
    logic                    pick_dir;
    logic                    pick_found;
`ifdef CALL_SCHED_TIMEOUT_EN
    logic [WDOG_W-1:0]       wdog_q, wdog_d;
    logic                    timeout_q, timeout_d;
`endif

    call_pick #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_pick (
        .pending_i (pending_q),
        .elev_f_i  (lift.elev_f_i),
        .dir_i     (dir_q),
        .target_o  (pick_floor),
        .dir_o     (pick_dir),
        .found_o   (pick_found)
    );

    assign floor_mask_c = NUM_FLOORS'(1) << req_floor_q;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        dir_d       = dir_q;
        req_floor_d = req_floor_q;
`ifdef CALL_SCHED_TIMEOUT_EN
        wdog_d      = wdog_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                if (pick_found) begin
                    state_d     = ST_OFFER;
                    req_floor_d = pick_floor;
                    dir_d       = pick_dir;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (lift.req_ack_i) begin
                    state_d   = ST_WAIT_DONE;
                    pending_d = pending_q & ~floor_mask_c;
`ifdef CALL_SCHED_TIMEOUT_EN
                    wdog_d    = '0;
`endif
                end
            end
            ST_WAIT_DONE: begin
                if (!lift.busy_i && (lift.elev_f_i == req_floor_q)) begin
                    state_d = ST_IDLE;
                end
`ifdef CALL_SCHED_TIMEOUT_EN
                else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                    // Give up on a stuck car: requeue its target and report.
                    if (wdog_d == WDOG_W'(TIMEOUT_CYCLES)) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                        pending_d = pending_q | floor_mask_c;
                    end
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        // New calls are ORed last so they beat a same-cycle clear.
        pending_d   = pending_d | hall_call | cab_call;
        req_valid_d = (state_d == ST_OFFER);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            dir_q       <= DIR_UP;
            req_valid_q <= 1'b0;
            req_floor_q <= '0;
`ifdef CALL_SCHED_TIMEOUT_EN
            wdog_q      <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            dir_q       <= dir_d;
            req_valid_q <= req_valid_d;
            req_floor_q <= req_floor_d;
`ifdef CALL_SCHED_TIMEOUT_EN
            wdog_q      <= wdog_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign lift.req_valid_o = req_valid_q;
    assign lift.req_floor_o = req_floor_q;
    assign dir_o            = dir_q;
    assign pending_o        = pending_q;
`ifdef CALL_SCHED_TIMEOUT_EN
    assign timeout_o        = timeout_q;
`else
    assign timeout_o        = 1'b0;
`endif

endmodule

// File: tb/tb_call_scheduler.sv
// Self-checking bench for call_scheduler: directed scenarios plus a randomized
// run against a sweep-ordering reference model.
module tb_call_scheduler;
    localparam int unsigned NF = 8;
    localparam int unsigned FW = 3;

    logic          clk;
    logic          rst_n;
    logic [NF-1:0] hall_call;
    logic [NF-1:0] cab_call;
    logic          dir_o;
    logic [NF-1:0] pending_o;
    logic          timeout_o;

    int total = 0;
    int bad   = 0;

    call_sched_if #(.FLOOR_W(FW)) lift ();

    call_scheduler #(
        .NUM_FLOORS (NF),
        .FLOOR_W    (FW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hall_call (hall_call),
        .cab_call  (cab_call),
        .lift      (lift),
        .dir_o     (dir_o),
        .pending_o (pending_o),
        .timeout_o (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL sim_watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_offer(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            if (lift.req_valid_o === 1'b1) ok = 1'b1;
            else step();
        end
    endtask

    task automatic serve(input logic [FW-1:0] fl);
        lift.req_ack_i = 1'b1;
        lift.busy_i    = 1'b1;
        step();
        lift.req_ack_i = 1'b0;
        lift.elev_f_i  = fl;
        lift.busy_i    = 1'b0;
        step();
    endtask

    // Reference selection: distance-based search over the pending set.
    function automatic void model_pick(input logic [NF-1:0] m, input int elev, input bit dir,
                                       output int tgt, output bit ndir);
        int up_best;
        int dn_best;
        up_best = -1;
        dn_best = -1;
        for (int f = 0; f < int'(NF); f++) begin
            if (m[f] == 1'b1) begin
                if (f > elev && (up_best < 0 || (f - elev) < (up_best - elev))) up_best = f;
                if (f < elev && (dn_best < 0 || (elev - f) < (elev - dn_best))) dn_best = f;
            end
        end
        if (m[elev[2:0]] == 1'b1) begin
            tgt  = elev;
            ndir = dir;
        end else begin
            if (dir) tgt = (up_best >= 0) ? up_best : dn_best;
            else     tgt = (dn_best >= 0) ? dn_best : up_best;
            ndir = (tgt > elev);
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        hall_call = '0;
        cab_call = '0;
        lift.elev_f_i = '0;
        lift.busy_i = 1'b0;
        lift.req_ack_i = 1'b0;
        step();
        step();
        total++;
        if (lift.req_valid_o !== 1'b0 || lift.req_floor_o !== 3'd0 || timeout_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: valid=%b floor=%0d timeout=%b want 0/0/0",
                     lift.req_valid_o, lift.req_floor_o, timeout_o);
        end
        total++;
        if (pending_o !== 8'h00 || dir_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: pending=%h dir=%b want 00/1", pending_o, dir_o);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (lift.req_valid_o !== 1'b0 || pending_o !== 8'h00 || dir_o !== 1'b1) begin
                bad++;
                $display("FAIL idle_quiet: cyc=%0d valid=%b pending=%h dir=%b want 0/00/1",
                         i, lift.req_valid_o, pending_o, dir_o);
            end
        end
    endtask

    task automatic test_latency();
        lift.elev_f_i = 3'd0;
        cab_call = 8'h20;
        step();
        cab_call = '0;
        total++;
        if (pending_o !== 8'h20 || lift.req_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL lat_pending: pending=%h valid=%b want 20/0", pending_o, lift.req_valid_o);
        end
        step();
        total++;
        if (lift.req_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL lat_select: valid=%b want 0", lift.req_valid_o);
        end
        step();
        total++;
        if (lift.req_valid_o !== 1'b1 || lift.req_floor_o !== 3'd5) begin
            bad++;
            $display("FAIL lat_offer: valid=%b floor=%0d want 1/5", lift.req_valid_o, lift.req_floor_o);
        end
        lift.req_ack_i = 1'b1;
        lift.busy_i = 1'b1;
        step();
        lift.req_ack_i = 1'b0;
        total++;
        if (pending_o[5] !== 1'b0 || lift.req_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL lat_ack: pending=%h valid=%b want bit5=0/0", pending_o, lift.req_valid_o);
        end
        lift.elev_f_i = 3'd5;
        lift.busy_i = 1'b0;
        step();
    endtask

    task automatic test_sweep();
        bit ok;
        total++;
        if (dir_o !== 1'b1) begin
            bad++;
            $display("FAIL sweep_dir_start: dir=%b want 1", dir_o);
        end
        lift.elev_f_i = 3'd3;
        cab_call = 8'h42;
        step();
        cab_call = '0;
        wait_offer(ok);
        total++;
        if (!ok || lift.req_floor_o !== 3'd6 || dir_o !== 1'b1) begin
            bad++;
            $display("FAIL sweep_first: ok=%b floor=%0d dir=%b want 1/6/1", ok, lift.req_floor_o, dir_o);
        end
        serve(3'd6);
        wait_offer(ok);
        total++;
        if (!ok || lift.req_floor_o !== 3'd1 || dir_o !== 1'b0) begin
            bad++;
            $display("FAIL sweep_second: ok=%b floor=%0d dir=%b want 1/1/0", ok, lift.req_floor_o, dir_o);
        end
        serve(3'd1);
    endtask

    task automatic test_ack_collision();
        bit ok;
        hall_call = 8'h04;
        step();
        hall_call = '0;
        wait_offer(ok);
        total++;
        if (!ok || lift.req_floor_o !== 3'd2 || dir_o !== 1'b1) begin
            bad++;
            $display("FAIL coll_offer: ok=%b floor=%0d dir=%b want 1/2/1", ok, lift.req_floor_o, dir_o);
        end
        lift.req_ack_i = 1'b1;
        lift.busy_i = 1'b1;
        hall_call = 8'h04;
        step();
        lift.req_ack_i = 1'b0;
        hall_call = '0;
        total++;
        if (pending_o[2] !== 1'b1 || lift.req_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL coll_keep: pending=%h valid=%b want bit2=1/0", pending_o, lift.req_valid_o);
        end
        lift.elev_f_i = 3'd2;
        lift.busy_i = 1'b0;
        step();
        wait_offer(ok);
        total++;
        if (!ok || lift.req_floor_o !== 3'd2) begin
            bad++;
            $display("FAIL coll_reoffer: ok=%b floor=%0d want 1/2", ok, lift.req_floor_o);
        end
        serve(3'd2);
    endtask

    task automatic test_timeout();
        bit ok;
        cab_call = 8'h10;
        step();
        cab_call = '0;
        wait_offer(ok);
        total++;
        if (!ok || lift.req_floor_o !== 3'd4) begin
            bad++;
            $display("FAIL to_offer: ok=%b floor=%0d want 1/4", ok, lift.req_floor_o);
        end
        lift.busy_i = 1'b1;
        lift.req_ack_i = 1'b1;
        step();
        lift.req_ack_i = 1'b0;
`ifdef CALL_SCHED_TIMEOUT_EN
        begin
            int n;
            bit seen;
            n = 0;
            seen = 1'b0;
            while (!seen && n < 300) begin
                step();
                n++;
                if (timeout_o === 1'b1) seen = 1'b1;
            end
            total++;
            if (n != 255) begin
                bad++;
                $display("FAIL to_cycles: timeout after %0d cycles want 255", n);
            end
            total++;
            if (pending_o[4] !== 1'b1) begin
                bad++;
                $display("FAIL to_requeue: pending=%h want bit4=1", pending_o);
            end
            step();
            total++;
            if (timeout_o !== 1'b0) begin
                bad++;
                $display("FAIL to_pulse: timeout=%b want 0", timeout_o);
            end
            wait_offer(ok);
            total++;
            if (!ok || lift.req_floor_o !== 3'd4) begin
                bad++;
                $display("FAIL to_reoffer: ok=%b floor=%0d want 1/4", ok, lift.req_floor_o);
            end
            serve(3'd4);
        end
`else
        begin
            bit seen_to;
            bit seen_valid;
            seen_to = 1'b0;
            seen_valid = 1'b0;
            for (int i = 0; i < 300; i++) begin
                step();
                if (timeout_o !== 1'b0) seen_to = 1'b1;
                if (lift.req_valid_o !== 1'b0) seen_valid = 1'b1;
            end
            total++;
            if (seen_to || seen_valid || pending_o !== 8'h00) begin
                bad++;
                $display("FAIL to_wait: timeout_seen=%b valid_seen=%b pending=%h want 0/0/00",
                         seen_to, seen_valid, pending_o);
            end
            lift.elev_f_i = 3'd4;
            lift.busy_i = 1'b0;
            step();
            step();
        end
`endif
    endtask

    task automatic test_reset_mid();
        bit ok;
        cab_call = 8'h80;
        step();
        cab_call = '0;
        wait_offer(ok);
        total++;
        if (!ok || lift.req_floor_o !== 3'd7) begin
            bad++;
            $display("FAIL rm_offer: ok=%b floor=%0d want 1/7", ok, lift.req_floor_o);
        end
        hall_call = 8'h20;
        step();
        hall_call = '0;
        step();
        total++;
        if (lift.req_valid_o !== 1'b1 || lift.req_floor_o !== 3'd7 || pending_o !== 8'ha0) begin
            bad++;
            $display("FAIL offer_hold: valid=%b floor=%0d pending=%h want 1/7/a0",
                     lift.req_valid_o, lift.req_floor_o, pending_o);
        end
        rst_n = 1'b0;
        step();
        total++;
        if (lift.req_valid_o !== 1'b0 || pending_o !== 8'h00 || lift.req_floor_o !== 3'd0 || dir_o !== 1'b1) begin
            bad++;
            $display("FAIL rm_reset: valid=%b pending=%h floor=%0d dir=%b want 0/00/0/1",
                     lift.req_valid_o, pending_o, lift.req_floor_o, dir_o);
        end
        rst_n = 1'b1;
        step();
        step();
        total++;
        if (lift.req_valid_o !== 1'b0 || pending_o !== 8'h00) begin
            bad++;
            $display("FAIL rm_idle: valid=%b pending=%h want 0/00", lift.req_valid_o, pending_o);
        end
    endtask

    task automatic test_random();
        logic [NF-1:0] m;
        logic [NF-1:0] m_last;
        bit            dir_m;
        bit            in_offer;
        bit            travelling;
        int            tgt;
        int            exp_f;
        bit            exp_dir;
        int            cd;
        rst_n = 1'b0;
        hall_call = '0;
        cab_call = '0;
        lift.req_ack_i = 1'b0;
        lift.busy_i = 1'b0;
        lift.elev_f_i = 3'($urandom_range(0, 7));
        step();
        rst_n = 1'b1;
        m = '0;
        m_last = '0;
        dir_m = 1'b1;
        in_offer = 1'b0;
        travelling = 1'b0;
        tgt = 0;
        cd = 0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            total++;
            if (pending_o !== m) begin
                bad++;
                $display("FAIL rnd_pending: cyc=%0d got %h want %h", cyc, pending_o, m);
            end
            if (lift.req_valid_o === 1'b1 && !in_offer) begin
                model_pick(m_last, int'(lift.elev_f_i), dir_m, exp_f, exp_dir);
                total++;
                if (lift.req_floor_o !== 3'(exp_f) || dir_o !== exp_dir) begin
                    bad++;
                    $display("FAIL rnd_offer: cyc=%0d floor=%0d dir=%b want %0d/%b",
                             cyc, lift.req_floor_o, dir_o, exp_f, exp_dir);
                end
                dir_m = exp_dir;
                tgt = exp_f;
                in_offer = 1'b1;
            end
            hall_call = '0;
            cab_call = '0;
            if (cyc < 600 && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) hall_call = 8'(1) << $urandom_range(0, 7);
                else                          cab_call  = 8'(1) << $urandom_range(0, 7);
            end
            lift.req_ack_i = 1'b0;
            if (travelling) begin
                if (cd == 0) begin
                    lift.elev_f_i = 3'(tgt);
                    lift.busy_i = 1'b0;
                    travelling = 1'b0;
                end else begin
                    cd--;
                end
            end else if (in_offer && $urandom_range(0, 2) == 0) begin
                lift.req_ack_i = 1'b1;
                lift.busy_i = 1'b1;
                travelling = 1'b1;
                in_offer = 1'b0;
                cd = $urandom_range(0, 4);
            end else if (lift.req_valid_o === 1'b0 && $urandom_range(0, 7) == 0) begin
                lift.req_ack_i = 1'b1;
            end
            m_last = m;
            if (lift.req_ack_i && lift.req_valid_o === 1'b1) m = m & ~(8'(1) << tgt);
            m = m | hall_call | cab_call;
            step();
        end
        lift.req_ack_i = 1'b0;
        hall_call = '0;
        cab_call = '0;
        total++;
        if (pending_o !== 8'h00) begin
            bad++;
            $display("FAIL rnd_drain: pending=%h want 00", pending_o);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_sweep();
        test_ack_collision();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
